// File: rtl/jolt80_mem_responder.sv
// Jolt80 data-bus responder: turns 8/16-bit CPU byte accesses into 16-bit word RAM
// accesses with byte enables, splitting misaligned 16-bit accesses into two words.
module jolt80_mem_responder #(
    parameter int ADDR_WIDTH = 16,
    parameter int RAM_RD_LAT = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_rdwr,
    input  logic [ADDR_WIDTH-1:0] addr_in,
    input  logic                  data_acc_sz,
    input  logic                  data_we,
    input  logic [15:0]           write_data_in,
    output logic [15:0]           read_data_out,
    output logic                  data_ready,
    output logic [ADDR_WIDTH-2:0] ram_addr,
    output logic [15:0]           ram_wdata,
    output logic [1:0]            ram_be,
    output logic                  ram_we,
    input  logic [15:0]           ram_rdata
);
    localparam int WW = ADDR_WIDTH - 1;
    localparam logic [1:0] LAT_LAST = 2'(RAM_RD_LAT - 1);

    typedef enum logic [2:0] {IDLE, ACC0, WAIT0, ACC1, WAIT1, DONE} state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  size_q, size_d;
    logic                  we_q, we_d;
    logic [15:0]           wdata_q, wdata_d;
    logic [1:0]            cnt_q, cnt_d;
    logic [15:0]           rd0_q, rd0_d;
    logic [15:0]           rd1_q, rd1_d;
    logic [15:0]           rdout_q, rdout_d;
    logic                  ready_q, ready_d;
    logic [WW-1:0]         ram_addr_q, ram_addr_d;
    logic [15:0]           ram_wdata_q, ram_wdata_d;
    logic [1:0]            ram_be_q, ram_be_d;
    logic                  ram_we_q, ram_we_d;

    logic          split_q, split_d;
    logic [WW-1:0] word1;
    logic [15:0]   result;

    assign split_q = size_q & addr_q[0];
    assign split_d = size_d & addr_d[0];
    // Second word wraps modulo the RAM word space.
    assign word1   = addr_q[ADDR_WIDTH-1:1] + WW'(1);

    always_comb begin
        result = {8'h00, (addr_q[0] ? rd0_q[15:8] : rd0_q[7:0])};
        if (size_q) begin
            result = addr_q[0] ? {rd1_q[7:0], rd0_q[15:8]} : rd0_q;
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        size_d  = size_q;
        we_d    = we_q;
        wdata_d = wdata_q;
        cnt_d   = cnt_q;
        rd0_d   = rd0_q;
        rd1_d   = rd1_q;
        rdout_d = rdout_q;
        case (state_q)
            IDLE: begin
                if (req_rdwr) begin
                    addr_d  = addr_in;
                    size_d  = data_acc_sz;
                    we_d    = data_we;
                    wdata_d = write_data_in;
                    state_d = ACC0;
                end
            end
            ACC0: begin
                cnt_d   = 2'd0;
                state_d = we_q ? (split_q ? ACC1 : DONE) : WAIT0;
            end
            WAIT0: begin
                if (cnt_q == LAT_LAST) begin
                    rd0_d   = ram_rdata;
                    state_d = split_q ? ACC1 : DONE;
                end else begin
                    cnt_d = cnt_q + 2'd1;
                end
            end
            ACC1: begin
                cnt_d   = 2'd0;
                state_d = we_q ? DONE : WAIT1;
            end
            WAIT1: begin
                if (cnt_q == LAT_LAST) begin
                    rd1_d   = ram_rdata;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 2'd1;
                end
            end
            DONE: begin
                if (!we_q) begin
                    rdout_d = result;
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // RAM-side outputs are computed for the state being entered so they register in step with it.
    always_comb begin
        ram_addr_d  = ram_addr_q;
        ram_wdata_d = ram_wdata_q;
        ram_be_d    = ram_be_q;
        ram_we_d    = 1'b0;
        ready_d     = (state_d == IDLE);
        case (state_d)
            ACC0: begin
                ram_addr_d = addr_d[ADDR_WIDTH-1:1];
                ram_we_d   = we_d;
                if (!size_d) begin
                    ram_be_d    = addr_d[0] ? 2'b10 : 2'b01;
                    ram_wdata_d = {wdata_d[7:0], wdata_d[7:0]};
                end else if (!split_d) begin
                    ram_be_d    = 2'b11;
                    ram_wdata_d = wdata_d;
                end else begin
                    ram_be_d    = 2'b10;
                    ram_wdata_d = {wdata_d[7:0], 8'h00};
                end
            end
            ACC1: begin
                ram_addr_d  = word1;
                ram_we_d    = we_d;
                ram_be_d    = 2'b01;
                ram_wdata_d = {8'h00, wdata_d[15:8]};
            end
            IDLE, DONE: ram_be_d = 2'b00;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            size_q      <= 1'b0;
            we_q        <= 1'b0;
            wdata_q     <= '0;
            cnt_q       <= '0;
            rd0_q       <= '0;
            rd1_q       <= '0;
            rdout_q     <= '0;
            ready_q     <= 1'b1;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
            ram_be_q    <= '0;
            ram_we_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            size_q      <= size_d;
            we_q        <= we_d;
            wdata_q     <= wdata_d;
            cnt_q       <= cnt_d;
            rd0_q       <= rd0_d;
            rd1_q       <= rd1_d;
            rdout_q     <= rdout_d;
            ready_q     <= ready_d;
            ram_addr_q  <= ram_addr_d;
            ram_wdata_q <= ram_wdata_d;
            ram_be_q    <= ram_be_d;
            ram_we_q    <= ram_we_d;
        end
    end

    assign read_data_out = rdout_q;
    assign data_ready    = ready_q;
    assign ram_addr      = ram_addr_q;
    assign ram_wdata     = ram_wdata_q;
    assign ram_be        = ram_be_q;
    assign ram_we        = ram_we_q;
endmodule

// File: tb/tb_jolt80_mem_responder.sv
// Directed bench for jolt80_mem_responder: one instance with RAM latency 1, one with latency 3,
// each backed by a behavioural byte-enabled word RAM.
module tb_jolt80_mem_responder;
    logic        clk = 1'b0;
    logic        reset_n;
    logic        req0, req3;
    logic [15:0] addr;
    logic        sz, we;
    logic [15:0] wd;

    logic [15:0] rdo0, rw0, rr0, rdo3, rw3, rr3;
    logic        rdy0, rwe0, rdy3, rwe3;
    logic [14:0] ra0, ra3;
    logic [1:0]  rb0, rb3;

    logic [15:0] mem0 [0:32767];
    logic [15:0] mem3 [0:32767];
    logic [15:0] p1, p2;
    int          we_cnt0 = 0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    jolt80_mem_responder #(.ADDR_WIDTH(16), .RAM_RD_LAT(1)) dut (
        .clk(clk), .reset(reset_n), .req_rdwr(req0), .addr_in(addr), .data_acc_sz(sz),
        .data_we(we), .write_data_in(wd), .read_data_out(rdo0), .data_ready(rdy0),
        .ram_addr(ra0), .ram_wdata(rw0), .ram_be(rb0), .ram_we(rwe0), .ram_rdata(rr0)
    );

    jolt80_mem_responder #(.ADDR_WIDTH(16), .RAM_RD_LAT(3)) dut3 (
        .clk(clk), .reset(reset_n), .req_rdwr(req3), .addr_in(addr), .data_acc_sz(sz),
        .data_we(we), .write_data_in(wd), .read_data_out(rdo3), .data_ready(rdy3),
        .ram_addr(ra3), .ram_wdata(rw3), .ram_be(rb3), .ram_we(rwe3), .ram_rdata(rr3)
    );

    always @(posedge clk) begin
        if (rwe0) begin
            if (rb0[0]) mem0[ra0][7:0]  <= rw0[7:0];
            if (rb0[1]) mem0[ra0][15:8] <= rw0[15:8];
            we_cnt0 <= we_cnt0 + 1;
        end
        rr0 <= mem0[ra0];
    end

    always @(posedge clk) begin
        if (rwe3) begin
            if (rb3[0]) mem3[ra3][7:0]  <= rw3[7:0];
            if (rb3[1]) mem3[ra3][15:8] <= rw3[15:8];
        end
        p1  <= mem3[ra3];
        p2  <= p1;
        rr3 <= p2;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end else begin
            $display("ok   %s: %h", tag, got);
        end
    endtask

    // One request; poke re-strobes req_rdwr (as a write) while busy to prove it is ignored.
    task automatic xact(input bit inst, input bit w, input bit s, input logic [15:0] a,
                        input logic [15:0] d, input bit poke,
                        output logic [15:0] rdata, output int busy, output logic [14:0] first_addr);
        int guard;
        guard = 0;
        while (!(inst ? rdy3 : rdy0) && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        we = w; sz = s; addr = a; wd = d;
        if (inst) req3 = 1'b1; else req0 = 1'b1;
        @(negedge clk);
        req0 = 1'b0; req3 = 1'b0;
        first_addr = inst ? ra3 : ra0;
        busy = 0;
        guard = 0;
        while (!(inst ? rdy3 : rdy0) && guard < 50) begin
            busy++;
            if (poke && busy == 2) begin
                we = 1'b1; sz = 1'b1; addr = 16'h0000; wd = 16'h1111;
                if (inst) req3 = 1'b1; else req0 = 1'b1;
            end else if (poke && busy == 3) begin
                req0 = 1'b0; req3 = 1'b0;
            end
            @(negedge clk);
            guard++;
        end
        if (guard >= 50) check("busy_timeout", 32'd1, 32'd0);
        rdata = inst ? rdo3 : rdo0;
        $display("xact inst=%0d we=%0d sz=%0d addr=%h wd=%h -> rd=%h busy=%0d", inst, w, s, a, d, rdata, busy);
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [15:0] rd;
        logic [14:0] fa;
        int          busy;
        int          cnt_before;

        reset_n = 1'b0; req0 = 1'b0; req3 = 1'b0;
        addr = '0; sz = 1'b0; we = 1'b0; wd = '0;
        repeat (3) @(negedge clk);
        check("rst_ready", 32'(rdy0), 32'd1);
        check("rst_rdata", 32'(rdo0), 32'h0000);
        check("rst_ram_we", 32'(rwe0), 32'd0);
        check("rst_ram_be", 32'(rb0), 32'd0);
        check("rst_ready3", 32'(rdy3), 32'd1);
        reset_n = 1'b1;
        @(negedge clk);

        // Preload through the responder with aligned 16-bit writes.
        xact(0, 1, 1, 16'h0020, 16'hBEEF, 0, rd, busy, fa);
        check("al_wr_busy", 32'(busy), 32'd2);
        check("al_wr_addr", 32'(fa), 32'h0010);
        check("al_wr_mem", 32'(mem0[15'h0010]), 32'hBEEF);
        xact(0, 1, 1, 16'h0040, 16'h5555, 0, rd, busy, fa);
        xact(0, 1, 1, 16'h0042, 16'h5555, 0, rd, busy, fa);
        xact(0, 1, 1, 16'hFFFE, 16'h5555, 0, rd, busy, fa);
        xact(0, 1, 1, 16'h0000, 16'h5555, 0, rd, busy, fa);
        xact(0, 1, 1, 16'h0060, 16'h5555, 0, rd, busy, fa);
        xact(0, 1, 1, 16'h0062, 16'h5555, 0, rd, busy, fa);
        xact(1, 1, 1, 16'h0000, 16'hBEEF, 0, rd, busy, fa);
        check("lat3_wr_busy", 32'(busy), 32'd2);

        // Aligned and byte reads.
        xact(0, 0, 1, 16'h0020, 16'h0000, 0, rd, busy, fa);
        check("rd16_data", 32'(rd), 32'hBEEF);
        check("rd16_busy", 32'(busy), 32'd3);
        check("rd16_addr", 32'(fa), 32'h0010);
        xact(0, 0, 0, 16'h0021, 16'h0000, 0, rd, busy, fa);
        check("rd8_odd", 32'(rd), 32'h00BE);
        xact(0, 0, 0, 16'h0020, 16'h0000, 0, rd, busy, fa);
        check("rd8_even", 32'(rd), 32'h00EF);

        // Misaligned write and readback.
        xact(0, 1, 1, 16'h0041, 16'h1234, 0, rd, busy, fa);
        check("split_wr_busy", 32'(busy), 32'd3);
        check("split_wr_w0", 32'(mem0[15'h0020]), 32'h3455);
        check("split_wr_w1", 32'(mem0[15'h0021]), 32'h5512);
        xact(0, 0, 1, 16'h0041, 16'h0000, 0, rd, busy, fa);
        check("split_rd_data", 32'(rd), 32'h1234);
        check("split_rd_busy", 32'(busy), 32'd5);
        xact(0, 1, 0, 16'h0043, 16'h0077, 0, rd, busy, fa);
        check("wr8_busy", 32'(busy), 32'd2);
        check("wr8_lane1", 32'(mem0[15'h0021]), 32'h7712);

        // Word-address wrap.
        xact(0, 1, 1, 16'hFFFF, 16'hABCD, 0, rd, busy, fa);
        check("wrap_w0", 32'(mem0[15'h7FFF]), 32'hCD55);
        check("wrap_w1", 32'(mem0[15'h0000]), 32'h55AB);
        xact(0, 0, 1, 16'hFFFF, 16'h0000, 0, rd, busy, fa);
        check("wrap_rd", 32'(rd), 32'hABCD);

        // Reset lands on the edge that would enter ACC1 of a split write.
        we = 1'b1; sz = 1'b1; addr = 16'h0061; wd = 16'h9876; req0 = 1'b1;
        @(negedge clk);
        req0 = 1'b0;
        cnt_before = we_cnt0;
        reset_n = 1'b0;
        @(negedge clk);
        check("abort_ready", 32'(rdy0), 32'd1);
        check("abort_ram_we", 32'(rwe0), 32'd0);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        check("abort_we_count", 32'(we_cnt0 - cnt_before), 32'd1);
        check("abort_w0", 32'(mem0[15'h0030]), 32'h7655);
        check("abort_w1", 32'(mem0[15'h0031]), 32'h5555);

        // Latency-3 instance: ignored strobe while busy, then consecutive byte reads.
        xact(1, 0, 0, 16'h0000, 16'h0000, 1, rd, busy, fa);
        check("lat3_rd0_data", 32'(rd), 32'h00EF);
        check("lat3_rd0_busy", 32'(busy), 32'd5);
        check("lat3_no_write", 32'(mem3[15'h0000]), 32'hBEEF);
        xact(1, 0, 0, 16'h0001, 16'h0000, 0, rd, busy, fa);
        check("lat3_rd1_data", 32'(rd), 32'h00BE);
        check("lat3_rd1_busy", 32'(busy), 32'd5);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
